// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and a bitwise LSB-first CRC-32 fold helper
// for the crc32 engine and its per-step datapath.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  // Widest block the whole-block fold helper accepts.
  localparam int CRC32_FOLD_MAX = 1024;

  typedef enum logic {IDLE, BUSY} crc32_state_t;

  // Folds the low nbits of data into acc, bit 0 first. The loop bound is
  // constant so the unused tail is pruned whenever nbits is a constant.
  function automatic logic [31:0] crc32_fold(
    input logic [31:0]               acc,
    input logic [CRC32_FOLD_MAX-1:0] data,
    input int                        nbits
  );
    logic [31:0] r;
    r = acc;
    for (int i = 0; i < CRC32_FOLD_MAX; i++) begin
      if (i < nbits) begin
        if (r[0] ^ data[i]) r = {1'b0, r[31:1]} ^ CRC32_POLY_REFL;
        else                r = {1'b0, r[31:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_step.sv
// Combinational CRC-32 update for one STEP_W-bit chunk, chunk bit 0 folded
// first; built as an unrolled chain of single-bit reflected LFSR steps.
module crc32_step
  import crc32_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic [31:0]       acc_in,
  input  logic [STEP_W-1:0] chunk,
  output logic [31:0]       acc_out
);

  for (genvar gi = 0; gi < STEP_W; gi++) begin : g_bit
    logic [31:0] prev;
    logic [31:0] next;
    logic        fb;

    if (gi == 0) begin : g_first
      assign prev = acc_in;
    end else begin : g_rest
      assign prev = g_bit[gi-1].next;
    end

    assign fb   = prev[0] ^ chunk[gi];
    assign next = {1'b0, prev[31:1]} ^ (fb ? CRC32_POLY_REFL : 32'h0);
  end

  assign acc_out = g_bit[STEP_W-1].next;

endmodule

// File: rtl/crc32.sv
// CRC-32 (IEEE 802.3) block engine: serial STEP_W bits per clock by default,
// or a whole-block fold when CRC32_SINGLE_CYCLE_EN is defined.
module crc32
  import crc32_pkg::*;
#(
  parameter int DATA_W = 320,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_raw,
  output logic [31:0]       crc,
  output logic              done
);

  if ((DATA_W % 8) != 0 || (DATA_W % STEP_W) != 0 ||
      !(STEP_W == 1 || STEP_W == 8 || STEP_W == 32) ||
      DATA_W > CRC32_FOLD_MAX) begin : g_bad_param
    $error("crc32: illegal DATA_W/STEP_W combination");
  end

`ifdef CRC32_SINGLE_CYCLE_EN

  logic [31:0] fold_crc;
  logic [31:0] fold_reg;
  logic        pend;

  always_comb begin
    fold_crc = crc32_fold(CRC32_INIT, CRC32_FOLD_MAX'(data_raw), DATA_W) ^ CRC32_XOROUT;
  end

  // Two-stage pipeline so every valid is accepted and done trails it by one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= 1'b0;
      fold_reg <= 32'h0;
      crc      <= 32'h0;
      done     <= 1'b0;
    end else begin
      pend <= valid;
      if (valid) fold_reg <= fold_crc;
      done <= pend;
      if (pend) crc <= fold_reg;
    end
  end

`else

  localparam int                NCHUNK = DATA_W / STEP_W;
  localparam int                CNT_W  = $clog2(NCHUNK) + 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(NCHUNK - 1);

  crc32_state_t      state;
  logic [DATA_W-1:0] shift;
  logic [31:0]       acc;
  logic [31:0]       acc_next;
  logic [CNT_W-1:0]  count;

  crc32_step #(
    .STEP_W (STEP_W)
  ) u_step (
    .acc_in  (acc),
    .chunk   (shift[STEP_W-1:0]),
    .acc_out (acc_next)
  );

  // valid is only looked at in IDLE, so requests during BUSY are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      crc   <= 32'h0;
      done  <= 1'b0;
      count <= '0;
      shift <= '0;
      acc   <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            shift <= data_raw;
            acc   <= CRC32_INIT;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          shift <= shift >> STEP_W;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            crc   <= acc_next ^ CRC32_XOROUT;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_crc32.sv
// Directed bench for crc32: four instances covering STEP_W 8/32/1 and block
// widths 320/72/32, with block CRCs known from standard check values.
module tb_crc32;

  // Bytes 0..3 = FF drive the register to zero; the tail then behaves like a
  // fresh CRC of the tail with its first four bytes inverted.
  localparam logic [319:0] V_CHK = {72'h3938373635CBCCCDCE, 216'h0, 32'hFFFFFFFF};
  localparam logic [319:0] V_RES = {32'hFFFFFFFF, 256'h0, 32'hFFFFFFFF};
  localparam logic [319:0] V_ONE = {288'h0, 32'hFFFFFFFF};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid [4];
  logic         done  [4];
  logic [31:0]  crc   [4];
  logic [319:0] d0;
  logic [319:0] d1;
  logic [71:0]  d2;
  logic [31:0]  d3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  crc32 #(.DATA_W(320), .STEP_W(8)) dut0 (
    .clk(clk), .rst(rst), .valid(valid[0]), .data_raw(d0), .crc(crc[0]), .done(done[0]));
  crc32 #(.DATA_W(320), .STEP_W(32)) dut1 (
    .clk(clk), .rst(rst), .valid(valid[1]), .data_raw(d1), .crc(crc[1]), .done(done[1]));
  crc32 #(.DATA_W(72), .STEP_W(8)) dut2 (
    .clk(clk), .rst(rst), .valid(valid[2]), .data_raw(d2), .crc(crc[2]), .done(done[2]));
  crc32 #(.DATA_W(32), .STEP_W(1)) dut3 (
    .clk(clk), .rst(rst), .valid(valid[3]), .data_raw(d3), .crc(crc[3]), .done(done[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %h", tag, got);
    end
  endtask

  function automatic int lat_of(input int sel);
`ifdef CRC32_SINGLE_CYCLE_EN
    return (sel >= 0) ? 1 : 1;
`else
    case (sel)
      0:       return 40;
      1:       return 10;
      2:       return 9;
      default: return 32;
    endcase
`endif
  endfunction

  task automatic load(input int sel, input logic [319:0] blk);
    case (sel)
      0:       d0 = blk;
      1:       d1 = blk;
      2:       d2 = blk[71:0];
      default: d3 = blk[31:0];
    endcase
  endtask

  // Called at the negedge just after the sampling edge; n = edges until done.
  task automatic wait_done(input int sel, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done[sel]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_block(input int sel, input logic [319:0] blk,
                           input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    load(sel, blk);
    valid[sel] = 1'b1;
    @(negedge clk);
    valid[sel] = 1'b0;
    wait_done(sel, n);
    check_eq({tag, "_lat"}, n, lat_of(sel));
    check_eq({tag, "_crc"}, crc[sel], exp);
    @(negedge clk);
    check_eq({tag, "_pulse"}, {31'h0, done[sel]}, 32'h0);
    check_eq({tag, "_hold"}, crc[sel], exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int m;
    int pulses;
    int bad;

    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("reset_crc%0d", i), crc[i], 32'h0);
      check_eq($sformatf("reset_done%0d", i), {31'h0, done[i]}, 32'h0);
    end
    rst = 1'b1;

    run_block(2, {248'h0, 72'h393837363534333231}, 32'hCBF43926, "chk72");
    run_block(3, 320'h0, 32'h2144DF1C, "zero32");
    run_block(3, {288'h0, 32'hFFFFFFFF}, 32'hFFFFFFFF, "ones32");
    run_block(0, V_CHK, 32'hCBF43926, "chk320");
    run_block(1, V_CHK, 32'hCBF43926, "chk320w");
    run_block(1, V_RES, 32'h2144DF1C, "res320w");
    run_block(0, V_ONE, 32'hFFFFFFFF, "one320");

    // valid held high until done is seen
    @(negedge clk);
    d0 = V_RES;
    valid[0] = 1'b1;
    n = -1; pulses = 0; bad = 0;
    for (int i = 0; i <= 120; i++) begin
      @(negedge clk);
      if (done[0]) begin
        pulses++;
        if (n < 0) begin
          n = i;
          valid[0] = 1'b0;
        end
      end
      if (n >= 0 && crc[0] !== 32'h2144DF1C) bad++;
      if (n >= 0 && i >= n + 20) break;
    end
    check_eq("held_lat", n, lat_of(0));
`ifdef CRC32_SINGLE_CYCLE_EN
    check_eq("held_pulses", pulses, 2);
`else
    check_eq("held_pulses", pulses, 1);
`endif
    check_eq("held_stable", bad, 0);
    valid[0] = 1'b0;

    // reset 10 cycles into a block
    @(negedge clk);
    d0 = V_CHK;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_crc", crc[0], 32'h0);
    check_eq("rst_mid_done", {31'h0, done[0]}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done[0]) pulses++;
    end
    check_eq("rst_no_done", pulses, 0);
    check_eq("rst_crc_after", crc[0], 32'h0);
    run_block(0, V_RES, 32'h2144DF1C, "after_rst");

    // back-to-back: new valid in the done cycle
    @(negedge clk);
    d0 = V_CHK;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_done(0, n);
    check_eq("b2b_first_lat", n, lat_of(0));
    check_eq("b2b_first_crc", crc[0], 32'hCBF43926);
    d0 = V_RES;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    m = -1; bad = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done[0]) begin
        m = i;
        break;
      end
      if (crc[0] !== 32'hCBF43926) bad++;
    end
    check_eq("b2b_second_lat", m, lat_of(0));
    check_eq("b2b_second_crc", crc[0], 32'h2144DF1C);
    check_eq("b2b_first_held", bad, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
